// File: rtl/vga_timing_gen_if.sv
// Video-timing bundle from the raster generator to the frame-buffer/PPU output stage.
interface vga_timing_gen_if;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       req;
  logic       line_start;
  logic       frame_start;

  modport master (output hsync, vsync, de, pix_x, pix_y, req, line_start, frame_start);
  modport slave  (input  hsync, vsync, de, pix_x, pix_y, req, line_start, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster generator in the pixel-clock domain: waits for a stable PLL lock,
// then produces registered sync/enable/coordinate timing plus an early fetch request.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PREFETCH = 2,
  parameter int SETTLE   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  output logic              running,
  vga_timing_gen_if.master  vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || PREFETCH < 1 || PREFETCH > 8 || SETTLE < 1)
  begin : g_param_chk
    $error("vga_timing_gen: timing parameters out of range");
  end

  typedef enum logic [1:0] {ST_WAIT_LOCK, ST_SETTLE, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic          lk_meta, lk;

  logic       hsync_q, vsync_q, de_q, req_q, line_start_q, frame_start_q;
  logic       hsync_d, vsync_d, de_d, req_d, line_start_d, frame_start_d;
  logic [9:0] pix_x_q, pix_y_q, pix_x_d, pix_y_d;
  logic [10:0] h_ext, v_ext, h_la, v_la;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk      <= lk_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_WAIT_LOCK;
      settle_q <= '0;
      h_q      <= '0;
      v_q      <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      h_q      <= h_d;
      v_q      <= v_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    h_d      = '0;
    v_d      = '0;
    unique case (state_q)
      ST_WAIT_LOCK: if (lk) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (!lk)                          state_d = ST_WAIT_LOCK;
        else if (settle_q == SETTLE_LAST) state_d = ST_RUN;
        else                              settle_d = settle_q + 1'b1;
      end
      ST_RUN: begin
        if (!lk) state_d = ST_WAIT_LOCK;
        else if (h_q == H_LAST) begin
          v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
          v_d = v_q;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  // Look-ahead position for req: PREFETCH < H_TOTAL, so at most one line carry.
  always_comb begin
    h_ext = {1'b0, h_q};
    v_ext = {1'b0, v_q};
    h_la  = h_ext + 11'(PREFETCH);
    v_la  = v_ext;
    if (h_la >= H_TOT) begin
      h_la = h_la - H_TOT;
      v_la = (v_q == V_LAST) ? '0 : v_ext + 11'd1;
    end
  end

  // Output registers fall back to idle on the same edge the FSM leaves RUN.
  always_comb begin
    hsync_d       = ~HS_POL;
    vsync_d       = ~VS_POL;
    de_d          = 1'b0;
    req_d         = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    pix_x_d       = '0;
    pix_y_d       = '0;
    if (state_q == ST_RUN && lk) begin
      de_d          = (h_ext < H_ACT) && (v_ext < V_ACT);
      hsync_d       = (h_ext >= HS_BEG && h_ext < HS_END) ? HS_POL : ~HS_POL;
      vsync_d       = (v_ext >= VS_BEG && v_ext < VS_END) ? VS_POL : ~VS_POL;
      req_d         = (h_la < H_ACT) && (v_la < V_ACT);
      line_start_d  = de_d && (h_q == '0);
      frame_start_d = de_d && (h_q == '0) && (v_q == '0);
      pix_x_d       = de_d ? h_q : '0;
      pix_y_d       = de_d ? v_q : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      req_q         <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      req_q         <= req_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
    end
  end

  assign running         = (state_q == ST_RUN);
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.de          = de_q;
  assign vid.req         = req_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.pix_x       = pix_x_q;
  assign vid.pix_y       = pix_y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken raster (25x11) so whole frames stay short.
module tb_vga_timing_gen;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int PF = 2;
  localparam int ST = 16;
  localparam bit HSP = 1'b0, VSP = 1'b0;

  logic clk = 1'b0;
  logic rst_n, pll_locked, running;
  vga_timing_gen_if vid ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP), .PREFETCH(PF), .SETTLE(ST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .running(running), .vid(vid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int de_cnt = 0, req_cnt = 0, ls_cnt = 0, fs_cnt = 0;
  logic [26:0] sbq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] observed();
    return {running, vid.hsync, vid.vsync, vid.de, vid.req, vid.line_start,
            vid.frame_start, vid.pix_x, vid.pix_y};
  endfunction

  function automatic logic [26:0] idle(input bit run);
    return {run, ~HSP, ~VSP, 24'd0};
  endfunction

  // Output cycle k (k>=1 after RUN entry) describes raster position k-1.
  function automatic logic [26:0] expect_at(input int kk);
    int p, h, v, q, hq, vq;
    logic de, hs, vs, rq;
    if (kk == 0) return idle(1'b1);
    p  = (kk - 1) % FRAME;
    h  = p % HT;
    v  = p / HT;
    q  = (p + PF) % FRAME;
    hq = q % HT;
    vq = q / HT;
    de = (h < HA) && (v < VA);
    hs = (h >= HA + HF && h < HA + HF + HS) ? HSP : ~HSP;
    vs = (v >= VA + VF && v < VA + VF + VS) ? VSP : ~VSP;
    rq = (hq < HA) && (vq < VA);
    return {1'b1, hs, vs, de, rq, de && h == 0, de && h == 0 && v == 0,
            de ? 10'(h) : 10'd0, de ? 10'(v) : 10'd0};
  endfunction

  task automatic wait_running(input string tag, input int exp_edges);
    int n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!running && n < 200);
    check(tag, n, exp_edges);
  endtask

  task automatic sb_step();
    logic [26:0] e, o;
    @(posedge clk);
    k++;
    sbq.push_back(expect_at(k));
    @(negedge clk);
    e = sbq.pop_front();
    o = observed();
    check($sformatf("raster k=%0d", k), o, e);
    if (k <= FRAME) begin
      de_cnt  += int'(o[23]);
      req_cnt += int'(o[22]);
      ls_cnt  += int'(o[21]);
      fs_cnt  += int'(o[20]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", observed(), idle(1'b0));
    rst_n = 1'b1;
    wait_running("lock_to_run", 3 + ST);
    k = 0;
    check("run_entry_idle", observed(), expect_at(0));
    for (int i = 0; i < 2 * FRAME + 3 * HT + 7; i++) sb_step();
    check("de_per_frame", de_cnt, HA * VA);
    check("req_per_frame", req_cnt, HA * VA);
    check("line_starts", ls_cnt, VA);
    check("frame_starts", fs_cnt, 1);

    // Lock loss mid-frame: two more normal cycles, then idle.
    pll_locked = 1'b0;
    sb_step();
    sb_step();
    @(negedge clk);
    check("lock_loss_idle", observed(), idle(1'b0));
    repeat (2) @(negedge clk);
    check("wait_lock_idle", observed(), idle(1'b0));

    pll_locked = 1'b1;
    wait_running("relock_to_run", 3 + ST);
    k = 0;
    check("relock_entry_idle", observed(), expect_at(0));
    for (int i = 0; i < FRAME + 10; i++) sb_step();

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1 check("async_reset", observed(), idle(1'b0));
    pll_locked = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_lock_idle", observed(), idle(1'b0));

    // Short lock glitch while settling restarts the settle window.
    pll_locked = 1'b1;
    repeat (6) @(negedge clk);
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    pll_locked = 1'b1;
    wait_running("glitch_restart", 3 + ST);
    k = 0;
    for (int i = 0; i < 2 * HT; i++) sb_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
